binary_to_excess_3: RTL and testbench
=====================================

# binary_to_excess_3

Registered 4-bit binary to excess-3 code converter. Each accepted input code `a` produces `y = a + 3` on a 5-bit output one clock later, together with a valid strobe. An optional out-of-BCD-range flag is also produced. The block is a small datapath leaf, used wherever BCD digits must be presented in excess-3 form to downstream arithmetic or display logic.

## Interface
- No parameters. All widths are fixed.
- `clk`  input  1  sole clock; every register samples on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_valid`  input  1  qualifies `a` in the current cycle.
- `a`  input  4  unsigned binary input code, 0..15.
- `y`  output  5  registered excess-3 result, `a + 3`, range 3..18.
- `out_valid`  output  1  high for exactly the cycle after an accepted input.
- `bcd_err`  output  1  registered flag, high when the accepted `a` exceeds 9. Behaviour depends on the configuration macro.

## Operation
- Acceptance: an input is accepted on any rising edge where `in_valid`=1 and `rst`=0. There is no backpressure; the block accepts every cycle.
- Conversion uses an unsigned 5-bit add with no truncation: `y = {1'b0,a} + 5'd3`.
- All 16 codes are converted, including the non-BCD codes 10..15, which give 13..18. Overflow is impossible.
- When an input is accepted:
  - `y` loads `a+3`.
  - `out_valid` is set to 1.
  - `bcd_err` loads `(a > 9)`.
- When no input is accepted:
  - `y` and `bcd_err` hold their previous values.
  - `out_valid` is cleared to 0.
- `bcd_err` only qualifies the result. It never alters `y`.

## Timing
- Latency is 1 clock from the accepting edge to the result on `y`, `out_valid` and `bcd_err`.
- Throughput is 1 conversion per clock. Back-to-back accepted inputs produce back-to-back results with `out_valid` held high.
- Reset values: `y`=5'd0, `out_valid`=0, `bcd_err`=0. Note that `y`=0 is not a legal excess-3 code, which marks the not-yet-loaded state.
- Reset has priority over `in_valid` on the same edge. The input on that edge is discarded.
- Reset during a stream drops any in-flight result. The first output after `rst` deasserts comes one cycle after the next accepted input.
- All outputs come directly from flops, with no combinational path from inputs to outputs.

## Configuration
- Macro: `BIN2XS3_RANGE_CHECK_EN`.
- Defined: `bcd_err` is the registered `(a > 9)` flag described above.
- Undefined:
  - The `bcd_err` port remains present but is tied to constant 0.
  - No comparator or flop is built for it.
  - `y` and `out_valid` behave identically in both builds.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `in_valid`=1, `a`=5 -> `y`=0, `out_valid`=0, `bcd_err`=0 throughout.
- Exhaustive sweep: stream `a`=0..15 with `in_valid`=1 every cycle -> one cycle later `y`=3..18 in order, `out_valid` continuously 1, `bcd_err`=1 only for `a`=10..15 (always 0 when the macro is undefined).
- Hold: accept `a`=7, then `in_valid`=0 for 3 cycles with `a`=12 -> `y` stays 10, `out_valid` pulses for one cycle only, `bcd_err` stays 0.
- Boundaries: accept `a`=9, then `a`=10, then `a`=15 -> `y`=12/13/18 and `bcd_err`=0/1/1.
- Mid-stream reset: accept `a`=4, assert `rst` on the next edge with `in_valid`=1 and `a`=6 -> the cycle after reset gives `y`=0, `out_valid`=0; then accept `a`=2 -> `y`=5.
- Random: 20 random `a` values, one accepted every 2 cycles -> each result equals the stimulus plus 3 and is checked against a scoreboard.

Source files
------------

// File: rtl/binary_to_excess_3.sv
// binary_to_excess_3
//
// Registered 4-bit binary to excess-3 converter. An accepted code `a` is presented
// as `y = a + 3` one clock later, together with a one-cycle `out_valid` strobe.
// All outputs come straight from flops.
//
// Configuration macro: BIN2XS3_RANGE_CHECK_EN
//   defined   - `bcd_err` is a registered (a > 9) flag for the accepted code
//   undefined - `bcd_err` is tied to 0 and no logic is built for it
//
// Ports:
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset, wins over in_valid
//   in_valid   in   1  qualifies `a` this cycle
//   a          in   4  binary input code, 0..15
//   y          out  5  excess-3 result a+3 (0 after reset, 3..18 once loaded)
//   out_valid  out  1  high for the cycle after each accepted input
//   bcd_err    out  1  accepted code was not a BCD digit (see macro above)

`timescale 1ns / 1ps

module binary_to_excess_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    output logic [4:0] y,
    output logic       out_valid,
    output logic       bcd_err
);

    logic [4:0] y_d;
    logic [4:0] y_q;
    logic       out_valid_q;

    // Zero-extend before adding so codes 10..15 map to 13..18 without wrap.
    always_comb begin
        y_d = {1'b0, a} + 5'd3;
    end

    // y holds its last value when idle; y = 0 marks "never loaded".
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q         <= 5'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                y_q <= y_d;
            end
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

`ifdef BIN2XS3_RANGE_CHECK_EN
    logic bcd_err_d;
    logic bcd_err_q;

    always_comb begin
        bcd_err_d = (a > 4'd9);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_err_q <= 1'b0;
        end else if (in_valid) begin
            bcd_err_q <= bcd_err_d;
        end
    end

    assign bcd_err = bcd_err_q;
`else
    assign bcd_err = 1'b0;
`endif

endmodule

// File: tb/tb_binary_to_excess_3.sv
// Self-checking bench for binary_to_excess_3. A behavioural model (plain integer
// arithmetic on the driven stimulus) predicts every output after each clock edge;
// the random phase also uses a queue scoreboard of expected results.

`timescale 1ns / 1ps

module tb_binary_to_excess_3;

`ifdef BIN2XS3_RANGE_CHECK_EN
    localparam bit RangeEn = 1'b1;
`else
    localparam bit RangeEn = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] a;
    logic [4:0] y;
    logic       out_valid;
    logic       bcd_err;

    int checks;
    int errors;

    // Model state: what the outputs must show after the most recent edge.
    int exp_y;
    int exp_v;
    int exp_e;

    int sb_q[$];

    binary_to_excess_3 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .y         (y),
        .out_valid (out_valid),
        .bcd_err   (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the edge, then
    // compare all outputs 1ns after the edge.
    task automatic step(input bit r, input bit v, input int av);
        rst      = r;
        in_valid = v;
        a        = 4'(av);
        @(posedge clk);
        if (r) begin
            exp_y = 0;
            exp_v = 0;
            exp_e = 0;
        end else begin
            exp_v = v ? 1 : 0;
            if (v) begin
                exp_y = av + 3;
                exp_e = (RangeEn && av > 9) ? 1 : 0;
            end
        end
        #1;
        check("y", int'(y), exp_y);
        check("out_valid", int'(out_valid), exp_v);
        check("bcd_err", int'(bcd_err), exp_e);
    endtask

    initial begin
        int r;
        checks   = 0;
        errors   = 0;
        exp_y    = 0;
        exp_v    = 0;
        exp_e    = 0;
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 4'd5;

        // Reset held with a live input: outputs stay at reset values.
        step(1, 1, 5);
        step(1, 1, 5);
        check("rst_y", int'(y), 0);

        // Exhaustive back-to-back sweep.
        for (int i = 0; i < 16; i++) begin
            step(0, 1, i);
            check("sweep_y", int'(y), i + 3);
        end

        // Hold: one accept then idle with a changing input.
        step(0, 1, 7);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 12);
            check("hold_y", int'(y), 10);
            check("hold_err", int'(bcd_err), 0);
        end

        // BCD boundary codes.
        step(0, 1, 9);
        check("bnd9_y", int'(y), 12);
        check("bnd9_err", int'(bcd_err), 0);
        step(0, 1, 10);
        check("bnd10_y", int'(y), 13);
        check("bnd10_err", int'(bcd_err), RangeEn ? 1 : 0);
        step(0, 1, 15);
        check("bnd15_y", int'(y), 18);
        check("bnd15_err", int'(bcd_err), RangeEn ? 1 : 0);

        // Mid-stream reset discards the input on the reset edge.
        step(0, 1, 4);
        step(1, 1, 6);
        check("mrst_y", int'(y), 0);
        check("mrst_v", int'(out_valid), 0);
        step(0, 0, 6);
        check("mrst_idle_v", int'(out_valid), 0);
        step(0, 1, 2);
        check("mrst_y2", int'(y), 5);

        // Random: one accept every two cycles, scoreboarded.
        for (int i = 0; i < 20; i++) begin
            r = int'($urandom_range(0, 15));
            sb_q.push_back(r + 3);
            step(0, 1, r);
            if (out_valid && sb_q.size() > 0) begin
                check("rand_sb_y", int'(y), sb_q.pop_front());
            end else begin
                check("rand_sb_valid", int'(out_valid), 1);
            end
            step(0, 0, int'($urandom_range(0, 15)));
        end
        check("rand_sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
